// File: rtl/mem_addr_if.sv
// Bus between the control unit and the memory-address unit: address sources,
// request controls, and the registered address/status returned by the unit.
interface mem_addr_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SEL_W = 2
);
   logic [NSRC*WIDTH-1:0] src_addr;
   logic [SEL_W-1:0]      sel;
   logic [1:0]            size;
   logic                  req;
   logic [WIDTH-1:0]      mem_addr;
   logic                  busy;
   logic                  done;
   logic                  misalign;
   logic [WIDTH-1:0]      bad_addr;

   modport master (
      output src_addr, sel, size, req,
      input  mem_addr, busy, done, misalign, bad_addr
   );

   modport slave (
      input  src_addr, sel, size, req,
      output mem_addr, busy, done, misalign, bad_addr
   );
endinterface

// File: rtl/mem_addr_unit.sv
// Memory-address source mux: registers the selected address, holds it for
// LATENCY cycles, then pulses done; misaligned or illegal requests pulse misalign.
module mem_addr_unit #(
   parameter int WIDTH   = 32,
   parameter int NSRC    = 4,
   parameter int SEL_W   = 2,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   mem_addr_if.slave   bus
);
   localparam int               CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(LATENCY - 1);
   localparam logic [SEL_W:0]   NSRC_L = (SEL_W + 1)'(NSRC);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [WIDTH-1:0] mem_addr_r, mem_addr_s;
   logic [WIDTH-1:0] bad_addr_r, bad_addr_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             misalign_r, misalign_s;
   logic [WIDTH-1:0] sel_addr_s;
   logic             sel_ok_s;
   logic             aligned_s;

   // Reserved size 2'b11 is checked like a word access.
   function automatic logic is_aligned(input logic [1:0] low, input logic [1:0] sz);
      logic ok;
      case (sz)
         2'b01:   ok = (low[0] == 1'b0);
         2'b10:   ok = 1'b1;
         default: ok = (low == 2'b00);
      endcase
      return ok;
   endfunction

   // Source mux; an out-of-range select yields zero and is flagged illegal.
   always_comb begin
      sel_addr_s = '0;
      sel_ok_s   = ({1'b0, bus.sel} < NSRC_L);
      for (int i = 0; i < NSRC; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            sel_addr_s = bus.src_addr[i*WIDTH +: WIDTH];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
      aligned_s = is_aligned(sel_addr_s[1:0], bus.size);
   end

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      mem_addr_s = mem_addr_r;
      bad_addr_s = bad_addr_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      misalign_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!bus.req) begin
               state_s = ST_IDLE;
            end else if (!sel_ok_s) begin
               misalign_s = 1'b1;
               bad_addr_s = '0;
            end else if (!aligned_s) begin
               misalign_s = 1'b1;
               bad_addr_s = sel_addr_s;
            end else begin
               mem_addr_s = sel_addr_s;
               cnt_s      = CNT_LD;
               busy_s     = 1'b1;
               state_s    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Requests during an access are dropped without a fault check.
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_s = cnt_r - CNT_W'(1);
            end else begin
               busy_s  = 1'b0;
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         mem_addr_r <= '0;
         bad_addr_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         mem_addr_r <= mem_addr_s;
         bad_addr_r <= bad_addr_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         misalign_r <= misalign_s;
      end
   end

   assign bus.mem_addr = mem_addr_r;
   assign bus.bad_addr = bad_addr_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.misalign = misalign_r;
endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit: a 4-source unit and a 3-source unit
// share clock and reset; the 3-source unit exercises the illegal select.
module tb_mem_addr_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mem_addr_if #(.WIDTH(32), .NSRC(4), .SEL_W(2)) bus4 ();
   mem_addr_if #(.WIDTH(32), .NSRC(3), .SEL_W(2)) bus3 ();

   mem_addr_unit #(.WIDTH(32), .NSRC(4), .SEL_W(2), .LATENCY(2)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave));
   mem_addr_unit #(.WIDTH(32), .NSRC(3), .SEL_W(2), .LATENCY(2)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3.slave));

   // Advance one clock; outputs are observed 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus4.src_addr = {32'h0000_040C, 32'h0000_03F0, 32'h0000_0204, 32'h0000_0100};
      bus4.sel = 2'd0; bus4.size = 2'b00; bus4.req = 1'b0;
      bus3.src_addr = {32'h0000_03F0, 32'h0000_0204, 32'h0000_0100};
      bus3.sel = 2'd0; bus3.size = 2'b00; bus3.req = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      total++;
      if (bus4.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=%h", bus4.mem_addr, 32'h0); end
      total++;
      if ({bus4.busy, bus4.done, bus4.misalign} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus4.busy, bus4.done, bus4.misalign}); end
      total++;
      if (bus4.bad_addr !== 32'h0) begin bad++; $display("FAIL reset_bad_addr got=%h want=%h", bus4.bad_addr, 32'h0); end
   endtask

   task automatic test_word_access();
      bus4.sel = 2'd2; bus4.size = 2'b00; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      bus4.src_addr[2*32 +: 32] = 32'h0000_0500;
      total++;
      if (bus4.mem_addr !== 32'h3F0) begin bad++; $display("FAIL word_addr got=%h want=%h", bus4.mem_addr, 32'h3F0); end
      total++;
      if ({bus4.busy, bus4.done} !== 2'b10) begin bad++; $display("FAIL word_busy1 got=%b want=10", {bus4.busy, bus4.done}); end
      tick();
      total++;
      if ({bus4.busy, bus4.done, bus4.mem_addr} !== {2'b10, 32'h3F0}) begin bad++; $display("FAIL word_busy2 got=%b/%h want=10/3f0", {bus4.busy, bus4.done}, bus4.mem_addr); end
      tick();
      total++;
      if ({bus4.busy, bus4.done, bus4.mem_addr} !== {2'b01, 32'h3F0}) begin bad++; $display("FAIL word_done got=%b/%h want=01/3f0", {bus4.busy, bus4.done}, bus4.mem_addr); end
      tick();
      total++;
      if ({bus4.busy, bus4.done} !== 2'b00) begin bad++; $display("FAIL word_after got=%b want=00", {bus4.busy, bus4.done}); end
   endtask

   task automatic test_misalign();
      bus4.src_addr[0 +: 32] = 32'h0000_0102;
      bus4.sel = 2'd0; bus4.size = 2'b00; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      total++;
      if ({bus4.busy, bus4.done, bus4.misalign} !== 3'b001) begin bad++; $display("FAIL mis_word_flags got=%b want=001", {bus4.busy, bus4.done, bus4.misalign}); end
      total++;
      if ({bus4.bad_addr, bus4.mem_addr} !== {32'h102, 32'h3F0}) begin bad++; $display("FAIL mis_word_addrs got=%h/%h want=102/3f0", bus4.bad_addr, bus4.mem_addr); end
      tick();
      total++;
      if ({bus4.misalign, bus4.bad_addr} !== {1'b0, 32'h102}) begin bad++; $display("FAIL mis_pulse_len got=%b/%h want=0/102", bus4.misalign, bus4.bad_addr); end
      // Same address as a halfword is legal.
      bus4.size = 2'b01; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      total++;
      if ({bus4.busy, bus4.misalign, bus4.mem_addr} !== {2'b10, 32'h102}) begin bad++; $display("FAIL half_ok got=%b/%h want=10/102", {bus4.busy, bus4.misalign}, bus4.mem_addr); end
      tick(); tick();
      total++;
      if (bus4.done !== 1'b1) begin bad++; $display("FAIL half_done got=%b want=1", bus4.done); end
      tick();
      bus4.src_addr[0 +: 32] = 32'h0000_0103;
      bus4.size = 2'b01; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      total++;
      if ({bus4.busy, bus4.misalign, bus4.bad_addr} !== {2'b01, 32'h103}) begin bad++; $display("FAIL mis_half got=%b/%h want=01/103", {bus4.busy, bus4.misalign}, bus4.bad_addr); end
      tick();
      bus4.size = 2'b10; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      total++;
      if ({bus4.busy, bus4.misalign, bus4.mem_addr, bus4.bad_addr} !== {2'b10, 32'h103, 32'h103}) begin bad++; $display("FAIL byte_ok got=%b/%h/%h want=10/103/103", {bus4.busy, bus4.misalign}, bus4.mem_addr, bus4.bad_addr); end
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      int done_t[$];
      bus4.sel = 2'd1; bus4.size = 2'b00; bus4.req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) begin
            bus4.sel = 2'd3;
            total++;
            if (bus4.mem_addr !== 32'h204) begin bad++; $display("FAIL b2b_first got=%h want=%h", bus4.mem_addr, 32'h204); end
         end
         if (c == 1) begin
            total++;
            if ({bus4.busy, bus4.mem_addr} !== {1'b1, 32'h204}) begin bad++; $display("FAIL b2b_ignore got=%b/%h want=1/204", bus4.busy, bus4.mem_addr); end
         end
         if (c == 3) begin
            total++;
            if ({bus4.busy, bus4.done, bus4.mem_addr} !== {2'b10, 32'h40C}) begin bad++; $display("FAIL b2b_second got=%b/%h want=10/40c", {bus4.busy, bus4.done}, bus4.mem_addr); end
         end
         if (c == 4) bus4.req = 1'b0;
         if (bus4.done && bus4.misalign) begin
            total++; bad++;
            $display("FAIL b2b_exclusive got=11 want=not both");
         end
         if (bus4.done) done_t.push_back(c);
      end
      total++;
      if (done_t.size() !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", done_t.size()); end
      else begin
         total++;
         if (done_t[1] - done_t[0] !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", done_t[1] - done_t[0]); end
      end
   endtask

   task automatic test_illegal_sel();
      bus3.src_addr[0 +: 32] = 32'h0000_0102;
      bus3.sel = 2'd0; bus3.size = 2'b00; bus3.req = 1'b1;
      tick();
      total++;
      if ({bus3.misalign, bus3.bad_addr} !== {1'b1, 32'h102}) begin bad++; $display("FAIL n3_mis got=%b/%h want=1/102", bus3.misalign, bus3.bad_addr); end
      bus3.sel = 2'd3;
      tick();
      bus3.req = 1'b0;
      total++;
      if ({bus3.busy, bus3.done, bus3.misalign, bus3.bad_addr} !== {3'b001, 32'h0}) begin bad++; $display("FAIL n3_illegal got=%b/%h want=001/0", {bus3.busy, bus3.done, bus3.misalign}, bus3.bad_addr); end
      tick();
      total++;
      if ({bus3.busy, bus3.misalign} !== 2'b00) begin bad++; $display("FAIL n3_after got=%b want=00", {bus3.busy, bus3.misalign}); end
   endtask

   task automatic test_reset_mid_access();
      bus4.sel = 2'd2; bus4.size = 2'b00; bus4.req = 1'b1;
      tick();
      bus4.req = 1'b0;
      total++;
      if ({bus4.busy, bus4.mem_addr} !== {1'b1, 32'h500}) begin bad++; $display("FAIL mid_accept got=%b/%h want=1/500", bus4.busy, bus4.mem_addr); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({bus4.busy, bus4.done, bus4.misalign, bus4.mem_addr, bus4.bad_addr} !== {3'b000, 32'h0, 32'h0}) begin bad++; $display("FAIL mid_reset got=%b/%h/%h want=000/0/0", {bus4.busy, bus4.done, bus4.misalign}, bus4.mem_addr, bus4.bad_addr); end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if ({bus4.busy, bus4.done} !== 2'b00) begin bad++; $display("FAIL mid_no_done cyc=%0d got=%b want=00", c, {bus4.busy, bus4.done}); end
      end
   endtask

   initial begin
      test_reset();
      test_word_access();
      test_misalign();
      test_back_to_back();
      test_illegal_sel();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
